// File: rtl/pipe_adder.sv
// ---------------------------------------------------------------------------
// pipe_adder
//
// Segmented, pipelined adder/subtractor with valid/ready flow control on both
// sides. Each of the STAGES = WIDTH/SEG pipeline stages adds one SEG-bit slice
// of the operands using the carry registered by the stage before it. Operand
// bits that have not been added yet travel down the pipe with their partial
// sum, so every stage works only on data that belongs to its own operand set.
//
// Parameters
//   WIDTH : operand/sum width (a multiple of SEG, >= SEG)
//   SEG   : bits added per pipeline stage
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset
//   in_valid   : operand set on a/b/sub/cin is valid
//   in_ready   : operand set is accepted this cycle (when in_valid=1)
//   a, b       : operands
//   sub        : 0 = a+b+cin, 1 = a-b (cin ignored)
//   cin        : carry into bit 0 when sub=0
//   out_valid  : s/cout/ovf/zero hold a result
//   out_ready  : consumer takes the result this cycle
//   s          : sum/difference modulo 2^WIDTH
//   cout       : carry out of the MSB (for subtract: 1 = no borrow)
//   ovf        : signed two's-complement overflow
//   zero       : s == 0
// ---------------------------------------------------------------------------
module pipe_adder #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = WIDTH / SEG;

    // Subtraction is folded into the first stage as a + ~b + 1, so later
    // stages never need to know which operation they are performing.
    logic [WIDTH-1:0]  w_b_eff;
    logic              w_c0;
    logic [STAGES-1:0] w_stage_valid;
    logic [STAGES-1:0] w_adv;

    assign w_b_eff = sub ? ~b : b;
    assign w_c0    = sub | cin;

    // Advance chain: a stage moves when it is empty or its successor moves.
    // Evaluated from the output end back to the input so that in_ready sees
    // out_ready combinationally and a full pipe can accept and deliver in the
    // same cycle without a bubble.
    always_comb begin
        w_adv = '0;
        w_adv[STAGES-1] = ~w_stage_valid[STAGES-1] | out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_adv[k] = ~w_stage_valid[k] | w_adv[k+1];
        end
    end

    assign in_ready = w_adv[0] & ~rst;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            // LO   : bit position of the slice this stage adds
            // DONE : number of sum bits known after this stage
            // CUR  : operand bits still pending when this stage starts
            localparam int LO   = gi * SEG;
            localparam int DONE = (gi + 1) * SEG;
            localparam int CUR  = WIDTH - LO;

            logic [CUR-1:0]  w_a_cur;
            logic [CUR-1:0]  w_b_cur;
            logic            w_c_in;
            logic            w_v_in;
            logic [SEG:0]    w_seg;
            logic [DONE-1:0] w_sum_next;

            logic            r_valid;
            logic            r_carry;
            logic [DONE-1:0] r_sum;

            if (gi == 0) begin : g_src
                assign w_a_cur    = a;
                assign w_b_cur    = w_b_eff;
                assign w_c_in     = w_c0;
                assign w_v_in     = in_valid;
                assign w_sum_next = w_seg[SEG-1:0];
            end else begin : g_src
                assign w_a_cur    = g_stage[gi-1].g_rem.r_a_rem;
                assign w_b_cur    = g_stage[gi-1].g_rem.r_b_rem;
                assign w_c_in     = g_stage[gi-1].r_carry;
                assign w_v_in     = g_stage[gi-1].r_valid;
                // New slice goes on top of the lower sum computed upstream.
                assign w_sum_next = {w_seg[SEG-1:0], g_stage[gi-1].r_sum};
            end

            // The slice being added is always the lowest pending segment.
            assign w_seg = {1'b0, w_a_cur[SEG-1:0]}
                         + {1'b0, w_b_cur[SEG-1:0]}
                         + {{SEG{1'b0}}, w_c_in};

            assign w_stage_valid[gi] = r_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_carry <= 1'b0;
                    r_sum   <= '0;
                end else if (w_adv[gi]) begin
                    r_valid <= w_v_in;
                    r_carry <= w_seg[SEG];
                    r_sum   <= w_sum_next;
                end
            end

            // Upper operand segments not yet consumed ride along with the
            // partial sum. The last stage consumes everything, so it has none.
            if (gi < STAGES - 1) begin : g_rem
                logic [WIDTH-DONE-1:0] r_a_rem;
                logic [WIDTH-DONE-1:0] r_b_rem;

                always_ff @(posedge clk) begin
                    if (w_adv[gi]) begin
                        r_a_rem <= w_a_cur[CUR-1:SEG];
                        r_b_rem <= w_b_cur[CUR-1:SEG];
                    end
                end
            end

            // Final stage also produces the flags. The carry into the MSB is
            // recovered from the MSB sum bit: sum = a ^ b ^ carry_in.
            if (gi == STAGES - 1) begin : g_last
                logic w_msb_cin;
                logic r_ovf;
                logic r_zero;

                assign w_msb_cin = w_a_cur[SEG-1] ^ w_b_cur[SEG-1] ^ w_seg[SEG-1];

                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_ovf  <= 1'b0;
                        r_zero <= 1'b0;
                    end else if (w_adv[gi]) begin
                        r_ovf  <= w_msb_cin ^ w_seg[SEG];
                        r_zero <= (w_sum_next == '0);
                    end
                end
            end
        end
    endgenerate

    // Outputs come straight from the last stage's registers, so they are
    // inherently held while that stage is stalled by out_ready=0.
    assign out_valid = g_stage[STAGES-1].r_valid;
    assign s         = g_stage[STAGES-1].r_sum;
    assign cout      = g_stage[STAGES-1].r_carry;
    assign ovf       = g_stage[STAGES-1].g_last.r_ovf;
    assign zero      = g_stage[STAGES-1].g_last.r_zero;

endmodule

// File: tb/tb_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_pipe_adder
//
// Bench for pipe_adder. A 64/16 instance is driven through directed and
// random traffic; every delivered result is compared with an arithmetic model
// held in a queue in acceptance order. An 8/8 instance covers the single
// stage configuration.
// ---------------------------------------------------------------------------
module tb_pipe_adder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // 64-bit, 4-stage instance
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;

    // 8-bit, single-stage instance
    logic        in_valid1;
    logic        in_ready1;
    logic [7:0]  a1;
    logic [7:0]  b1;
    logic        cin1;
    logic        out_valid1;
    logic [7:0]  s1;
    logic        cout1;
    logic        ovf1;
    logic        zero1;

    pipe_adder #(.WIDTH(64), .SEG(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    pipe_adder #(.WIDTH(8), .SEG(8)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .sub       (1'b0),
        .cin       (cin1),
        .out_valid (out_valid1),
        .out_ready (1'b1),
        .s         (s1),
        .cout      (cout1),
        .ovf       (ovf1),
        .zero      (zero1)
    );

    typedef struct {
        logic [63:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          n_acc   = 0;
    int          n_del   = 0;
    logic        lat_check = 1'b0;

    // Values observed at the most recent sample point
    logic        cur_in_ready;
    logic        cur_out_valid;
    logic [63:0] cur_s;
    logic        cur_cout;
    logic        cur_ovf;
    logic        cur_zero;

    // Last delivered result
    logic [63:0] last_s;
    logic        last_cout;
    logic        last_ovf;
    logic        last_zero;

    // Reference: plain unsigned arithmetic for s/cout, sign-extended
    // arithmetic with a range test for ovf.
    function automatic exp_t model(input logic [63:0] ia, input logic [63:0] ib,
                                   input logic isub, input logic icin);
        exp_t               e;
        logic [64:0]        u;
        logic signed [65:0] sv;
        if (isub) begin
            u  = {1'b0, ia} - {1'b0, ib} + 65'h1_0000_0000_0000_0000;
            sv = $signed({{2{ia[63]}}, ia}) - $signed({{2{ib[63]}}, ib});
        end else begin
            u  = {1'b0, ia} + {1'b0, ib} + 65'(icin);
            sv = $signed({{2{ia[63]}}, ia}) + $signed({{2{ib[63]}}, ib}) + 66'(icin);
        end
        e.s    = u[63:0];
        e.cout = u[64];
        e.ovf  = (sv[65:63] != 3'b000) && (sv[65:63] != 3'b111);
        e.zero = (u[63:0] == 64'd0);
        e.cyc  = 0;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive on the falling edge, sample 1ns later, then let
    // the rising edge commit the transfers seen at the sample point.
    task automatic step(input logic iv, input logic [63:0] ia, input logic [63:0] ib,
                        input logic isub, input logic icin, input logic iordy,
                        input logic irst);
        logic acc;
        logic del;
        exp_t e;
        @(negedge clk);
        rst       = irst;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        sub       = isub;
        cin       = icin;
        out_ready = iordy;
        #1;
        cur_in_ready  = in_ready;
        cur_out_valid = out_valid;
        cur_s         = s;
        cur_cout      = cout;
        cur_ovf       = ovf;
        cur_zero      = zero;
        acc = iv && in_ready && !irst;
        del = out_valid && out_ready && !irst;
        if (del) begin
            last_s    = s;
            last_cout = cout;
            last_ovf  = ovf;
            last_zero = zero;
            n_del++;
            check("result_expected", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                $display("[TB] cyc %0d result s=%h cout=%0b ovf=%0b zero=%0b (exp s=%h)",
                         cyc, s, cout, ovf, zero, e.s);
                check("s", s, e.s);
                check("cout", 64'(cout), 64'(e.cout));
                check("ovf", 64'(ovf), 64'(e.ovf));
                check("zero", 64'(zero), 64'(e.zero));
                if (lat_check) check("latency", 64'(cyc - e.cyc), 64'd4);
            end
        end
        if (acc) begin
            e = model(ia, ib, isub, icin);
            e.cyc = cyc;
            q.push_back(e);
            n_acc++;
        end
        @(posedge clk);
        cyc++;
        if (irst) q.delete();
    endtask

    task automatic idle(input logic iordy);
        step(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, iordy, 1'b0);
    endtask

    // Send one set into an empty pipe and check the delivered fields directly.
    task automatic run_one(input string tag, input logic [63:0] ia, input logic [63:0] ib,
                           input logic isub, input logic icin, input logic [63:0] es,
                           input logic ec, input logic eo, input logic ez);
        int d0;
        d0 = n_del;
        step(1'b1, ia, ib, isub, icin, 1'b1, 1'b0);
        for (int i = 0; i < 8 && n_del == d0; i++) idle(1'b1);
        check({tag, "_delivered"}, 64'(n_del - d0), 64'd1);
        check({tag, "_s"}, last_s, es);
        check({tag, "_cout"}, 64'(last_cout), 64'(ec));
        check({tag, "_ovf"}, 64'(last_ovf), 64'(eo));
        check({tag, "_zero"}, 64'(last_zero), 64'(ez));
    endtask

    initial begin : stim
        int          a0;
        int          d0;
        logic [63:0] hold_s;
        logic        hold_c;
        logic        hold_o;
        logic        hold_z;
        logic        have_hold;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        out_ready = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

        // Reset, with in_valid asserted to show it is ignored
        step(1'b1, 64'd1, 64'd1, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 64'd1, 64'd1, 1'b0, 1'b0, 1'b1, 1'b1);
        check("rst_in_ready", 64'(cur_in_ready), 64'd0);
        idle(1'b1);
        check("post_rst_in_ready", 64'(cur_in_ready), 64'd1);
        check("post_rst_out_valid", 64'(cur_out_valid), 64'd0);
        check("post_rst_s", cur_s, 64'd0);
        check("post_rst_cout", 64'(cur_cout), 64'd0);
        check("post_rst_ovf", 64'(cur_ovf), 64'd0);
        check("post_rst_zero", 64'(cur_zero), 64'd0);
        check("post_rst_in_ready1", 64'(in_ready1), 64'd1);
        check("post_rst_out_valid1", 64'(out_valid1), 64'd0);

        // Directed corner cases, latency checked as well
        lat_check = 1'b1;
        run_one("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                64'd0, 1'b1, 1'b0, 1'b1);
        run_one("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        run_one("subneg", 64'd5, 64'd7, 1'b1, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_one("cin", 64'h0000_FFFF_0000_FFFF, 64'h0, 1'b0, 1'b1,
                64'h0000_FFFF_0001_0000, 1'b0, 1'b0, 1'b0);

        // Full throughput: 100 random sets back to back
        a0 = n_acc;
        d0 = n_del;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, {$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
        for (int i = 0; i < 6; i++) idle(1'b1);
        check("tput_accepted", 64'(n_acc - a0), 64'd100);
        check("tput_delivered", 64'(n_del - d0), 64'd100);
        check("tput_queue_empty", 64'(q.size()), 64'd0);

        // Backpressure: out_ready=0 for 10 cycles with in_valid=1
        lat_check = 1'b0;
        a0 = n_acc;
        d0 = n_del;
        have_hold = 1'b0;
        hold_s = '0; hold_c = 1'b0; hold_o = 1'b0; hold_z = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, {$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (have_hold) begin
                check("bp_hold_valid", 64'(cur_out_valid), 64'd1);
                check("bp_hold_s", cur_s, hold_s);
                check("bp_hold_flags", 64'({cur_cout, cur_ovf, cur_zero}),
                      64'({hold_c, hold_o, hold_z}));
            end else if (cur_out_valid) begin
                have_hold = 1'b1;
                hold_s = cur_s; hold_c = cur_cout; hold_o = cur_ovf; hold_z = cur_zero;
            end
        end
        check("bp_accepted", 64'(n_acc - a0), 64'd4);
        check("bp_in_ready", 64'(cur_in_ready), 64'd0);
        check("bp_seen_valid", 64'(have_hold), 64'd1);
        for (int i = 0; i < 6; i++) idle(1'b1);
        check("bp_drained", 64'(n_del - d0), 64'd4);
        check("bp_queue_empty", 64'(q.size()), 64'd0);

        // Reset with three sets in flight
        for (int i = 0; i < 3; i++) begin
            step(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        check("rmf_in_flight", 64'(q.size()), 64'd3);
        d0 = n_del;
        step(1'b1, 64'd3, 64'd4, 1'b0, 1'b0, 1'b1, 1'b1);
        check("rmf_rst_in_ready", 64'(cur_in_ready), 64'd0);
        idle(1'b1);
        check("rmf_in_ready", 64'(cur_in_ready), 64'd1);
        check("rmf_out_valid_0", 64'(cur_out_valid), 64'd0);
        for (int i = 0; i < 5; i++) begin
            idle(1'b1);
            check("rmf_out_valid", 64'(cur_out_valid), 64'd0);
        end
        check("rmf_no_result", 64'(n_del - d0), 64'd0);

        // Single-stage instance: 0x80 + 0x80 + 1
        @(negedge clk);
        in_valid1 = 1'b1; a1 = 8'h80; b1 = 8'h80; cin1 = 1'b1;
        #1;
        check("ss_in_ready", 64'(in_ready1), 64'd1);
        @(negedge clk);
        in_valid1 = 1'b0;
        #1;
        $display("[TB] single-stage result s=%h cout=%0b ovf=%0b zero=%0b",
                 s1, cout1, ovf1, zero1);
        check("ss_out_valid", 64'(out_valid1), 64'd1);
        check("ss_s", 64'(s1), 64'h01);
        check("ss_cout", 64'(cout1), 64'd1);
        check("ss_ovf", 64'(ovf1), 64'd1);
        check("ss_zero", 64'(zero1), 64'd0);
        @(negedge clk);
        #1;
        check("ss_out_valid_clear", 64'(out_valid1), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
PIPE_ADDER -- requirements
Module: pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand/sum width in bits; legal values are multiples of SEG, >= SEG.
REQ-002 SHALL have parameter SEG, default 16: segment width added per pipeline stage; STAGES = WIDTH/SEG.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: operand set on a, b, sub, cin is valid.
REQ-006 SHALL have port in_ready, output, 1: block accepts an operand set this cycle.
REQ-007 SHALL have port a, input, WIDTH: operand A.
REQ-008 SHALL have port b, input, WIDTH: operand B.
REQ-009 SHALL have port sub, input, 1: 0 = A+B+cin; 1 = A+~B+1 (A-B); cin ignored when sub=1.
REQ-010 SHALL have port cin, input, 1: carry into bit 0 when sub=0.
REQ-011 SHALL have port out_valid, output, 1: result fields are valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the result this cycle.
REQ-013 SHALL have port s, output, WIDTH: sum/difference modulo 2^WIDTH.
REQ-014 SHALL have port cout, output, 1: carry out of the MSB (for sub: 1 = no borrow).
REQ-015 SHALL have port ovf, output, 1: signed two's-complement overflow.
REQ-016 SHALL have port zero, output, 1: s == 0.

Function
REQ-017 SHALL accept an operand set on a transfer cycle: in_valid=1 and in_ready=1.
REQ-018 SHALL deliver a result on a transfer cycle: out_valid=1 and out_ready=1.
REQ-019 SHALL be a STAGES-deep pipeline; stage k adds bits [(k+1)*SEG-1 : k*SEG] using the carry registered by stage k-1; stage 0 uses cin, or 1 when sub=1.
REQ-020 SHALL carry each operand set's unconsumed upper segments, and its already-computed lower sum segments, alongside it through the stages, so no stage holds a stale operand.
REQ-021 SHALL give a result latency of exactly STAGES cycles from the accept edge to out_valid=1 when there is no backpressure.
REQ-022 SHALL sustain one accept per cycle at full throughput (out_ready held 1).
REQ-023 SHALL advance stage k when it is empty or stage k+1 advances this cycle; the last stage advances when out_valid=0 or out_ready=1.
REQ-024 SHALL drive in_ready = (stage 0 empty) or (stage 0 advances this cycle); in_ready is combinational from out_ready through the advance chain.
REQ-025 SHALL hold s, cout, ovf, zero and out_valid stable while out_valid=1 and out_ready=0.
REQ-026 SHALL never drop or duplicate an operand set, and SHALL keep results in acceptance order.
REQ-027 SHALL compute ovf = carry into MSB XOR carry out of MSB, evaluated in the final stage.
REQ-028 SHALL compute zero registered from the final s value, valid together with out_valid.
REQ-029 SHALL wrap s modulo 2^WIDTH, with the carry reported only on cout; e.g. all-ones + 1 gives s=0, cout=1.
REQ-030 SHALL allow an accept and a delivery in the same cycle when the pipeline is full, with no bubble inserted.
REQ-031 SHALL accept STAGES=1 (WIDTH=SEG) as legal, giving a single-register adder with latency 1.

Reset
REQ-032 SHALL clear all stage valid bits on rst=1 at a clock edge; out_valid=0, s=0, cout=0, ovf=0, zero=0 in the following cycle.
REQ-033 SHALL drive in_ready=0 while rst=1, and SHALL drive in_ready=1 in the first cycle after rst deasserts.
REQ-034 SHALL discard all in-flight operand sets when rst asserts mid-operation; none may appear on the output after reset.
REQ-035 SHALL ignore in_valid in any cycle where rst=1.

Verification
REQ-036 SHALL cover carry ripple: WIDTH=64, SEG=16, a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0, cin=0 -> after 4 cycles s=0, cout=1, ovf=0, zero=1.
REQ-037 SHALL cover signed overflow and subtract: a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> s=0x8000_0000_0000_0000, ovf=1, cout=0; then a=5, b=7, sub=1 -> s=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0.
REQ-038 SHALL cover full throughput: 100 random back-to-back sets with out_ready=1 -> 100 results in order matching a reference model, first at cycle 4, one per cycle thereafter.
REQ-039 SHALL cover backpressure: out_ready=0 for 10 cycles while in_valid=1 -> exactly 4 sets accepted, then in_ready=0 and outputs held stable; on out_ready=1, results drain in order with no loss.
REQ-040 SHALL cover reset mid-flight: accept 3 sets, assert rst for 1 cycle -> out_valid stays 0 and no result appears; in_ready=1 the next cycle.
REQ-041 SHALL cover the single-stage corner: WIDTH=SEG=8, a=0x80, b=0x80, cin=1 -> after 1 cycle s=0x01, cout=1, ovf=1.
